// File: rtl/stream_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_gen_if
// Purpose  : valid/ready byte stream between stream_gen and the read FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_gen_if;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in;

  modport master (output data_out, output valid_out, input ready_in);
  modport slave  (input data_out, input valid_out, output ready_in);
endinterface
`default_nettype wire

// File: rtl/stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : stream_gen
// Purpose  : rate-controlled counter/LFSR byte source with overrun statistics.
// Revision : 1.0 - initial release
// ============================================================================
module stream_gen #(
  parameter int         CNT_WIDTH = 16,
  parameter logic [7:0] SEED      = 8'h01
) (
  input  wire                  clk_in,
  input  wire                  reset_in,
  input  wire                  enable_in,
  input  wire                  mode_in,
  input  wire [3:0]            ceiling_in,
  stream_gen_if.master         bus,
  output logic [CNT_WIDTH-1:0] sent_out,
  output logic [7:0]           overrun_out
);

  localparam logic [7:0] c_LFSR_MASK = 8'hB8;

  logic [3:0]           r_p;
  logic [7:0]           r_count;
  logic [7:0]           r_lfsr;
  logic                 r_mode;
  logic [7:0]           r_data;
  logic                 r_valid;
  logic [CNT_WIDTH-1:0] r_sent;
  logic [7:0]           r_overrun;

  logic       w_tick;
  logic       w_xfer;
  logic [7:0] w_lfsr_step;
  logic [7:0] w_next_count;
  logic [7:0] w_next_lfsr;

  // ">=" so a lowered ceiling takes effect at once instead of wrapping p.
  assign w_tick       = enable_in && (r_p >= ceiling_in);
  assign w_xfer       = r_valid && bus.ready_in;
  assign w_lfsr_step  = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? c_LFSR_MASK : 8'h00);
  // Only the source that produced the accepted byte advances.
  assign w_next_count = (w_xfer && !r_mode) ? r_count + 8'd1 : r_count;
  assign w_next_lfsr  = (w_xfer &&  r_mode) ? w_lfsr_step    : r_lfsr;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_p       <= 4'd0;
      r_count   <= 8'h00;
      r_lfsr    <= SEED;
      r_mode    <= 1'b0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_sent    <= '0;
      r_overrun <= 8'h00;
    end else begin
      if (!enable_in || w_tick) r_p <= 4'd0;
      else                      r_p <= r_p + 4'd1;

      r_count <= w_next_count;
      r_lfsr  <= w_next_lfsr;

      if (w_xfer) r_sent <= r_sent + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

      if (w_tick) begin
        if (!r_valid || w_xfer) begin
          r_data  <= mode_in ? w_next_lfsr : w_next_count;
          r_valid <= 1'b1;
          r_mode  <= mode_in;
        end else if (r_overrun != 8'hFF) begin
          r_overrun <= r_overrun + 8'd1;
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;
  assign sent_out      = r_sent;
  assign overrun_out   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_gen
// Purpose  : directed self-checking bench for stream_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_in = 1'b0;
  logic        mode_in = 1'b0;
  logic [3:0]  ceiling_in = 4'd0;
  logic [15:0] sent_out;
  logic [7:0]  overrun_out;

  int vectors = 0;
  int errors  = 0;

  stream_gen_if bus ();

  stream_gen #(.CNT_WIDTH(16), .SEED(8'h01)) dut (
    .clk_in      (clk),
    .reset_in    (rst),
    .enable_in   (enable_in),
    .mode_in     (mode_in),
    .ceiling_in  (ceiling_in),
    .bus         (bus),
    .sent_out    (sent_out),
    .overrun_out (overrun_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.ready_in = 1'b0;

    // Reset state
    step(1);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'h00);
    chk("rst_sent", 32'(sent_out), 32'd0);
    chk("rst_overrun", 32'(overrun_out), 32'd0);

    // ceiling=3: first byte after edge 4, then one every 4 cycles
    enable_in = 1'b1; mode_in = 1'b0; ceiling_in = 4'd3; bus.ready_in = 1'b1;
    do_reset();
    step(3);
    chk("c3_wait", 32'(bus.valid_out), 32'd0);
    step(1);
    chk("c3_v0", 32'(bus.valid_out), 32'd1);
    chk("c3_d0", 32'(bus.data_out), 32'h00);
    step(1);
    chk("c3_drop", 32'(bus.valid_out), 32'd0);
    chk("c3_sent1", 32'(sent_out), 32'd1);
    step(3);
    chk("c3_v1", 32'(bus.valid_out), 32'd1);
    chk("c3_d1", 32'(bus.data_out), 32'h01);
    step(4);
    chk("c3_d2", 32'(bus.data_out), 32'h02);
    chk("c3_sent2", 32'(sent_out), 32'd2);

    // ceiling=0, back-to-back, counter wrap, 300 accepted
    ceiling_in = 4'd0;
    do_reset();
    for (int k = 1; k <= 301; k++) begin
      step(1);
      chk("b2b_valid", 32'(bus.valid_out), 32'd1);
      chk("b2b_data", 32'(bus.data_out), 32'((k - 1) % 256));
    end
    chk("b2b_sent", 32'(sent_out), 32'd300);

    // Back-pressure: ten dropped ticks, then no skipped value
    bus.ready_in = 1'b0;
    do_reset();
    step(1);
    chk("bp_d0", 32'(bus.data_out), 32'h00);
    step(10);
    chk("bp_hold", 32'(bus.data_out), 32'h00);
    chk("bp_overrun", 32'(overrun_out), 32'd10);
    chk("bp_sent0", 32'(sent_out), 32'd0);
    bus.ready_in = 1'b1;
    step(1);
    chk("bp_d1", 32'(bus.data_out), 32'h01);
    chk("bp_sent1", 32'(sent_out), 32'd1);
    chk("bp_valid", 32'(bus.valid_out), 32'd1);

    // Overrun saturates
    bus.ready_in = 1'b0;
    do_reset();
    step(300);
    chk("ovr_sat", 32'(overrun_out), 32'hFF);

    // LFSR sequence: hand values, never zero, period 255
    bus.ready_in = 1'b1; mode_in = 1'b1;
    do_reset();
    step(1);
    chk("lfsr_1", 32'(bus.data_out), 32'h01);
    step(1);
    chk("lfsr_2", 32'(bus.data_out), 32'hB8);
    step(1);
    chk("lfsr_3", 32'(bus.data_out), 32'h5C);
    step(1);
    chk("lfsr_4", 32'(bus.data_out), 32'h2E);
    step(1);
    chk("lfsr_5", 32'(bus.data_out), 32'h17);
    step(1);
    chk("lfsr_6", 32'(bus.data_out), 32'hB3);
    for (int k = 7; k <= 255; k++) begin
      step(1);
      chk("lfsr_nz", 32'(bus.data_out == 8'h00), 32'd0);
      chk("lfsr_nrep", 32'(bus.data_out == 8'h01), 32'd0);
    end
    step(1);
    chk("lfsr_256", 32'(bus.data_out), 32'h01);
    chk("lfsr_sent", 32'(sent_out), 32'd255);

    // Mode switching preserves the idle source
    mode_in = 1'b0;
    do_reset();
    step(1);
    chk("mx_0", 32'(bus.data_out), 32'h00);
    mode_in = 1'b1;
    step(1);
    chk("mx_1", 32'(bus.data_out), 32'h01);
    step(1);
    chk("mx_2", 32'(bus.data_out), 32'hB8);
    mode_in = 1'b0;
    step(1);
    chk("mx_3", 32'(bus.data_out), 32'h01);
    mode_in = 1'b1;
    step(1);
    chk("mx_4", 32'(bus.data_out), 32'h5C);

    // Enable falls with a byte pending
    mode_in = 1'b0; bus.ready_in = 1'b0;
    do_reset();
    step(1);
    chk("en_v", 32'(bus.valid_out), 32'd1);
    enable_in = 1'b0;
    step(3);
    chk("en_hold_v", 32'(bus.valid_out), 32'd1);
    chk("en_hold_d", 32'(bus.data_out), 32'h00);
    chk("en_no_ovr", 32'(overrun_out), 32'd0);
    bus.ready_in = 1'b1;
    step(1);
    chk("en_acc_v", 32'(bus.valid_out), 32'd0);
    chk("en_acc_s", 32'(sent_out), 32'd1);
    step(3);
    chk("en_idle_v", 32'(bus.valid_out), 32'd0);
    chk("en_idle_s", 32'(sent_out), 32'd1);

    // Asynchronous reset in the middle of an offer
    enable_in = 1'b1;
    do_reset();
    step(4);
    chk("ar_pre_d", 32'(bus.data_out), 32'h03);
    chk("ar_pre_s", 32'(sent_out), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(bus.valid_out), 32'd0);
    chk("ar_data", 32'(bus.data_out), 32'h00);
    chk("ar_sent", 32'(sent_out), 32'd0);
    #1 rst = 1'b0;
    step(1);
    chk("ar_rst_d", 32'(bus.data_out), 32'h00);
    chk("ar_rst_v", 32'(bus.valid_out), 32'd1);
    chk("ar_rst_s", 32'(sent_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
